// File: rtl/fifo_sync_param_if.sv
// Handshake and status bundle for the single-clock FIFO.
// master drives requests; slave is the FIFO side.
interface fifo_sync_param_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 7
);

  logic [DATA_WIDTH-1:0] write_data;
  logic                  write_enable;
  logic                  read_enable;
  logic [DATA_WIDTH-1:0] read_data;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [ADDR_WIDTH:0]   fill_count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output write_data,
    output write_enable,
    output read_enable,
    input  read_data,
    input  full,
    input  empty,
    input  almost_full,
    input  almost_empty,
    input  fill_count,
    input  overflow,
    input  underflow
  );

  modport slave (
    input  write_data,
    input  write_enable,
    input  read_enable,
    output read_data,
    output full,
    output empty,
    output almost_full,
    output almost_empty,
    output fill_count,
    output overflow,
    output underflow
  );

endinterface

// File: rtl/fifo_sync_param.sv
// Single-clock parametrised FIFO with fill level,
// programmable almost flags and sticky error flags.
module fifo_sync_param #(
  parameter int DATA_WIDTH          = 16,
  parameter int ADDR_WIDTH          = 7,
  parameter int ALMOST_FULL_THRESH  = 120,
  parameter int ALMOST_EMPTY_THRESH = 8
) (
  input  logic           clock,
  input  logic           reset_n,
  fifo_sync_param_if.slave bus
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int PW    = ADDR_WIDTH + 1;

  localparam logic [PW-1:0] AF_T =
    PW'(ALMOST_FULL_THRESH);
  localparam logic [PW-1:0] AE_T =
    PW'(ALMOST_EMPTY_THRESH);
  localparam logic [PW-1:0] ONE = PW'(1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [PW-1:0]         wptr;
  logic [PW-1:0]         rptr;
  logic [PW-1:0]         count;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  ovf;
  logic                  unf;

  logic [ADDR_WIDTH-1:0] waddr;
  logic [ADDR_WIDTH-1:0] raddr;
  logic                  full_w;
  logic                  empty_w;
  logic                  wr_acc;
  logic                  rd_acc;

  assign waddr = wptr[ADDR_WIDTH-1:0];
  assign raddr = rptr[ADDR_WIDTH-1:0];

  // Wrap bit tells full from empty when addresses match.
  assign empty_w = (wptr == rptr);
  assign full_w  =
    (waddr == raddr) &&
    (wptr[ADDR_WIDTH] != rptr[ADDR_WIDTH]);

  assign wr_acc = bus.write_enable & ~full_w;
  assign rd_acc = bus.read_enable  & ~empty_w;

  // Storage is deliberately left out of reset.
  always_ff @(posedge clock) begin
    if (wr_acc) begin
      mem[waddr] <= bus.write_data;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr_acc) begin
        wptr <= wptr + ONE;
      end
      if (rd_acc) begin
        rptr <= rptr + ONE;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      rdata <= '0;
    end else if (rd_acc) begin
      rdata <= mem[raddr];
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      count <= '0;
    end else begin
      unique case (1'b1)
        (wr_acc & ~rd_acc): count <= count + ONE;
        (rd_acc & ~wr_acc): count <= count - ONE;
        default:            count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      if (bus.write_enable & full_w) begin
        ovf <= 1'b1;
      end
      if (bus.read_enable & empty_w) begin
        unf <= 1'b1;
      end
    end
  end

  assign bus.read_data    = rdata;
  assign bus.full         = full_w;
  assign bus.empty        = empty_w;
  assign bus.fill_count   = count;
  assign bus.almost_full  = (count >= AF_T);
  assign bus.almost_empty = (count <= AE_T);
  assign bus.overflow     = ovf;
  assign bus.underflow    = unf;

endmodule

// File: tb/tb_fifo_sync_param.sv
// Directed bench for fifo_sync_param at DEPTH=16,
// AF=14, AE=2, with hand-computed expectations.
module tb_fifo_sync_param;

  logic clock;
  logic reset_n;
  int   checks;
  int   errors;

  fifo_sync_param_if #(
    .DATA_WIDTH(16),
    .ADDR_WIDTH(4)
  ) bus ();

  fifo_sync_param #(
    .DATA_WIDTH(16),
    .ADDR_WIDTH(4),
    .ALMOST_FULL_THRESH(14),
    .ALMOST_EMPTY_THRESH(2)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs
  // are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic write_n(
    input logic [15:0] base,
    input int          n
  );
    for (int k = 0; k < n; k++) begin
      bus.write_data   = base + 16'(k);
      bus.write_enable = 1'b1;
      step();
    end
    bus.write_enable = 1'b0;
  endtask

  task automatic read_n(
    input string       tag,
    input logic [15:0] base,
    input int          n
  );
    for (int k = 0; k < n; k++) begin
      bus.read_enable = 1'b1;
      step();
      chk(tag, 32'(bus.read_data),
          32'(base + 16'(k)));
    end
    bus.read_enable = 1'b0;
  endtask

  initial begin
    checks           = 0;
    errors           = 0;
    reset_n          = 1'b0;
    bus.write_data   = '0;
    bus.write_enable = 1'b0;
    bus.read_enable  = 1'b0;
    step();
    step();

    chk("rst_empty", 32'(bus.empty), 32'd1);
    chk("rst_aempty", 32'(bus.almost_empty), 32'd1);
    chk("rst_full", 32'(bus.full), 32'd0);
    chk("rst_afull", 32'(bus.almost_full), 32'd0);
    chk("rst_count", 32'(bus.fill_count), 32'd0);
    chk("rst_rdata", 32'(bus.read_data), 32'd0);
    chk("rst_ovf", 32'(bus.overflow), 32'd0);
    chk("rst_unf", 32'(bus.underflow), 32'd0);

    reset_n = 1'b1;
    step();

    for (int i = 1; i <= 16; i++) begin
      bus.write_data   = 16'(i);
      bus.write_enable = 1'b1;
      step();
      chk("fill_count", 32'(bus.fill_count), 32'(i));
      chk("fill_afull", 32'(bus.almost_full),
          32'(i >= 14));
      chk("fill_aempty", 32'(bus.almost_empty),
          32'(i <= 2));
      chk("fill_full", 32'(bus.full), 32'(i == 16));
      chk("fill_empty", 32'(bus.empty), 32'd0);
    end
    bus.write_enable = 1'b0;

    for (int i = 1; i <= 16; i++) begin
      bus.read_enable = 1'b1;
      step();
      chk("drain_data", 32'(bus.read_data), 32'(i));
      chk("drain_count", 32'(bus.fill_count),
          32'(16 - i));
    end
    bus.read_enable = 1'b0;
    chk("drain_empty", 32'(bus.empty), 32'd1);
    chk("drain_unf", 32'(bus.underflow), 32'd0);

    write_n(16'h0100, 10);
    read_n("wrap_a", 16'h0100, 10);
    write_n(16'h0200, 12);
    chk("wrap_count", 32'(bus.fill_count), 32'd12);
    read_n("wrap_b", 16'h0200, 12);
    chk("wrap_empty", 32'(bus.empty), 32'd1);
    chk("wrap_zero", 32'(bus.fill_count), 32'd0);

    write_n(16'h0300, 5);
    for (int j = 0; j < 20; j++) begin
      bus.write_data   = 16'h0305 + 16'(j);
      bus.write_enable = 1'b1;
      bus.read_enable  = 1'b1;
      step();
      chk("rw_count", 32'(bus.fill_count), 32'd5);
      chk("rw_data", 32'(bus.read_data),
          32'(16'h0300 + 16'(j)));
    end
    bus.write_enable = 1'b0;
    bus.read_enable  = 1'b0;
    read_n("rw_tail", 16'h0314, 5);
    chk("rw_empty", 32'(bus.empty), 32'd1);

    write_n(16'h0400, 16);
    chk("of_full", 32'(bus.full), 32'd1);
    chk("of_pre", 32'(bus.overflow), 32'd0);
    bus.write_data   = 16'hDEAD;
    bus.write_enable = 1'b1;
    bus.read_enable  = 1'b1;
    step();
    bus.write_enable = 1'b0;
    bus.read_enable  = 1'b0;
    chk("of_count", 32'(bus.fill_count), 32'd15);
    chk("of_flag", 32'(bus.overflow), 32'd1);
    chk("of_data", 32'(bus.read_data), 32'h0400);
    read_n("of_rest", 16'h0401, 15);
    chk("of_empty", 32'(bus.empty), 32'd1);

    bus.read_enable = 1'b1;
    step();
    bus.read_enable = 1'b0;
    chk("uf_flag", 32'(bus.underflow), 32'd1);
    chk("uf_data", 32'(bus.read_data), 32'h040F);
    chk("uf_count", 32'(bus.fill_count), 32'd0);
    for (int j = 0; j < 10; j++) begin
      step();
      chk("uf_sticky", 32'(bus.underflow), 32'd1);
    end
    chk("of_sticky", 32'(bus.overflow), 32'd1);

    bus.write_data   = 16'h0055;
    bus.write_enable = 1'b1;
    bus.read_enable  = 1'b1;
    step();
    bus.write_enable = 1'b0;
    bus.read_enable  = 1'b0;
    chk("ew_count", 32'(bus.fill_count), 32'd1);
    chk("ew_data", 32'(bus.read_data), 32'h040F);
    read_n("ew_read", 16'h0055, 1);

    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    chk("clr_unf", 32'(bus.underflow), 32'd0);
    chk("clr_ovf", 32'(bus.overflow), 32'd0);

    write_n(16'h0500, 7);
    chk("mid_count", 32'(bus.fill_count), 32'd7);
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    chk("mid_zero", 32'(bus.fill_count), 32'd0);
    chk("mid_empty", 32'(bus.empty), 32'd1);
    write_n(16'hBEEF, 1);
    read_n("mid_beef", 16'hBEEF, 1);
    chk("mid_end", 32'(bus.empty), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
